// File: rtl/linebuf_sched_pkg.sv
// Shared definitions for the line-buffered edge-detection pipeline.
// The gauss/grad/nms/dualth stages and the frame sequencer all import these values,
// so they agree on the frame geometry and on the pipeline latency.
package linebuf_sched_pkg;

  // Default frame geometry.
  localparam int unsigned IMG_W_DEF  = 640;
  localparam int unsigned IMG_H_DEF  = 480;
  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned ROW_W_DEF  = 11;
  localparam int unsigned NLINES_DEF = 4;

  // Pipeline latency before the first output pixel: whole lines, then extra pixels.
  localparam int unsigned LAT_ROWS_DEF = 3;
  localparam int unsigned LAT_COLS_DEF = 4;

  // Frame state, as presented on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_STREAM = 2'b10,
    ST_FLUSH  = 2'b11
  } state_e;

endpackage

// File: rtl/linebuf_sched_if.sv
// Control bundle between the stream controller and the frame sequencer.
// The sequencer is the slave: it takes the advance/stream strobes and drives
// position, line-buffer RAM control and emission flags.
interface linebuf_sched_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned ROW_W  = 11,
  parameter int unsigned NLINES = 4
);
  logic              en;
  logic              in_valid;
  logic              in_last;
  logic              abort;
  logic              in_ready;
  logic [1:0]        state;
  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [NLINES-1:0] wr_sel;
  logic              ram_wen;
  logic              edg;
  logic              out_emit;
  logic              out_last;
  logic              frame_done;
  logic              err_short;

  modport master (
    output en, in_valid, in_last, abort,
    input  in_ready, state, col, row, waddr, raddr, wr_sel, ram_wen, edg,
    input  out_emit, out_last, frame_done, err_short
  );

  modport slave (
    input  en, in_valid, in_last, abort,
    output in_ready, state, col, row, waddr, raddr, wr_sel, ram_wen, edg,
    output out_emit, out_last, frame_done, err_short
  );
endinterface

// File: rtl/linebuf_pos_cnt.sv
// Pixel position counter: column/row, one-hot line-buffer rotation and border flag.
// Row keeps counting past IMG_H-1 during the flush so the dummy lines stay addressed.
module linebuf_pos_cnt #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned ROW_W  = 11,
  parameter int unsigned NLINES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  output logic [ADDR_W-1:0] col,
  output logic [ROW_W-1:0]  row,
  output logic [NLINES-1:0] wr_sel,
  output logic              edg
);

  logic [ADDR_W-1:0] col_q;
  logic [ROW_W-1:0]  row_q;
  logic [NLINES-1:0] wr_sel_q;

  // Column/row advance with line wrap; clr returns to the frame origin and beats adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      wr_sel_q <= NLINES'(1);
    end else if (clr) begin
      col_q    <= '0;
      row_q    <= '0;
      wr_sel_q <= NLINES'(1);
    end else if (adv) begin
      if (col_q == ADDR_W'(IMG_W - 1)) begin
        col_q    <= '0;
        row_q    <= row_q + ROW_W'(1);
        wr_sel_q <= {wr_sel_q[NLINES-2:0], wr_sel_q[NLINES-1]};
      end else begin
        col_q <= col_q + ADDR_W'(1);
      end
    end
  end

  // Border flag for the current position.
  always_comb begin
    edg = (col_q == '0) || (col_q == ADDR_W'(IMG_W - 1)) ||
          (row_q == '0) || (row_q == ROW_W'(IMG_H - 1));
  end

  assign col    = col_q;
  assign row    = row_q;
  assign wr_sel = wr_sel_q;

endmodule

// File: rtl/linebuf_sched.sv
// Frame sequencer for the line-buffered edge-detection pipeline.
// Tracks IDLE/LOAD/STREAM/FLUSH, gates input acceptance, drives line-buffer RAM control
// and flags which advances produce a valid output pixel.
module linebuf_sched
  import linebuf_sched_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ROW_W    = ROW_W_DEF,
  parameter int unsigned NLINES   = NLINES_DEF,
  parameter int unsigned LAT_ROWS = LAT_ROWS_DEF,
  parameter int unsigned LAT_COLS = LAT_COLS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  linebuf_sched_if.slave  bus
);

  localparam int unsigned TOTAL   = IMG_W * IMG_H;
  localparam int unsigned CNT_W   = $clog2(TOTAL + 1);
  // Last pixel of the fill phase, split into row/col so no multiplier is needed.
  localparam int unsigned LAT_P   = LAT_ROWS * IMG_W + LAT_COLS - 1;
  localparam int unsigned LAT_ROW = LAT_P / IMG_W;
  localparam int unsigned LAT_COL = LAT_P % IMG_W;

  state_e            state_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic              frame_done_q;
  logic              err_short_q;

  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  row;
  logic              in_ready, adv, emit, last, clr, at_lat, at_end;

  // Input is refused while flushing and for the frame_done cycle; abort suppresses the advance.
  always_comb begin
    in_ready = (state_q != ST_FLUSH) && !frame_done_q;
    adv      = rst_n && !bus.abort && bus.en &&
               ((state_q == ST_FLUSH) || (bus.in_valid && in_ready));
    emit     = adv && ((state_q == ST_STREAM) || (state_q == ST_FLUSH)) &&
               (out_cnt_q < CNT_W'(TOTAL));
    last     = emit && (out_cnt_q == CNT_W'(TOTAL - 1));
    clr      = bus.abort || last;
    at_lat   = (row == ROW_W'(LAT_ROW)) && (col == ADDR_W'(LAT_COL));
    at_end   = (row == ROW_W'(IMG_H - 1)) && (col == ADDR_W'(IMG_W - 1));
  end

  linebuf_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W),
    .NLINES (NLINES)
  ) u_pos_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (adv),
    .clr    (clr),
    .col    (col),
    .row    (row),
    .wr_sel (bus.wr_sel),
    .edg    (bus.edg)
  );

  // Frame FSM with output counter, done pulse and sticky short-frame flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.abort) begin
        state_q   <= ST_IDLE;
        out_cnt_q <= '0;
      end else if (adv) begin
        if (emit) begin
          out_cnt_q <= last ? '0 : out_cnt_q + CNT_W'(1);
        end
        unique case (state_q)
          ST_IDLE: begin
            state_q     <= ST_LOAD;
            err_short_q <= 1'b0;
          end
          ST_LOAD: begin
            if (bus.in_last) begin
              state_q     <= ST_FLUSH;
              err_short_q <= 1'b1;
            end else if (at_lat) begin
              state_q <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            // A late or missing tlast is tolerated; only an early one is an error.
            if (at_end) begin
              state_q <= ST_FLUSH;
            end else if (bus.in_last) begin
              state_q     <= ST_FLUSH;
              err_short_q <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (last) begin
              state_q      <= ST_IDLE;
              frame_done_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.state      = state_q;
  assign bus.col        = col;
  assign bus.row        = row;
  assign bus.waddr      = col;
  assign bus.raddr      = col;
  assign bus.ram_wen    = adv;
  assign bus.out_emit   = emit;
  assign bus.out_last   = last;
  assign bus.frame_done = frame_done_q;
  assign bus.err_short  = err_short_q;

endmodule

// File: tb/tb_linebuf_sched.sv
// Bench for linebuf_sched on an 8x6 frame. Stimulus pushes the expected position/state of
// every emission into a queue; a negedge monitor pops and compares whenever out_emit is high.
module tb_linebuf_sched;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    int col;
    int row;
    int st;
    int last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];

  linebuf_sched_if #(.ADDR_W(11), .ROW_W(11), .NLINES(4)) bus ();

  linebuf_sched #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_emit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("emit_col", 32'(bus.col), 32'(e.col));
        chk("emit_row", 32'(bus.row), 32'(e.row));
        chk("emit_state", 32'(bus.state), 32'(e.st));
        chk("emit_last", 32'(bus.out_last), 32'(e.last));
      end
    end else if (rst_n && bus.out_last) begin
      chk("last_without_emit", 32'd1, 32'd0);
    end
  end

  task automatic chk_origin(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_col"}, 32'(bus.col), 32'd0);
    chk({tag, "_row"}, 32'(bus.row), 32'd0);
    chk({tag, "_wr_sel"}, 32'(bus.wr_sel), 32'd1);
  endtask

  // One frame. tlast_p: advance index carrying tlast; gaps: drop in_valid on alternate
  // STREAM cycles; stop_p: advance index at which to abort (or reset if use_rst).
  task automatic frame(input int tlast_p, input bit gaps, input int stop_p, input bit use_rst);
    int a, emitted, cyc, start, exp_st;
    bit v, flush;
    exp_t e;
    a = 0;
    emitted = 0;
    cyc = 0;
    start = (tlast_p < 28) ? tlast_p + 1 : 28;
    while (emitted < 48) begin
      if (cyc > 400) begin
        chk("frame_timeout", 32'(emitted), 32'd48);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      flush = (a > tlast_p);
      v = 1'b1;
      if (gaps && a >= 28 && !flush && (cyc % 2 == 0)) v = 1'b0;
      bus.en       = 1'b1;
      bus.in_valid = v && !flush;
      bus.in_last  = v && !flush && (a == tlast_p);
      if (a == stop_p) begin
        if (use_rst) begin
          #2 rst_n = 1'b0;
          #1;
          chk_origin("rst");
          chk("rst_emit", 32'(bus.out_emit), 32'd0);
          chk("rst_wen", 32'(bus.ram_wen), 32'd0);
          chk("rst_ready", 32'(bus.in_ready), 32'd1);
          chk("rst_done", 32'(bus.frame_done), 32'd0);
          bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
          @(posedge clk); #2 rst_n = 1'b1;
        end else begin
          bus.abort = 1'b1;
          @(negedge clk);
          chk("abort_wen", 32'(bus.ram_wen), 32'd0);
          @(posedge clk); #1;
          bus.abort = 1'b0; bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
          chk_origin("abort");
          chk("abort_done", 32'(bus.frame_done), 32'd0);
          @(posedge clk); #1;
          chk("abort_done2", 32'(bus.frame_done), 32'd0);
        end
        chk("stop_q_empty", 32'(exp_q.size()), 32'd0);
        return;
      end
      if (!v) begin
        @(negedge clk);
        chk("gap_wen", 32'(bus.ram_wen), 32'd0);
        chk("gap_col", 32'(bus.col), 32'(a % W));
        continue;
      end
      if (a >= start) begin
        e.col = a % W; e.row = a / W; e.st = flush ? 3 : 2; e.last = (emitted == 47) ? 1 : 0;
        exp_q.push_back(e);
        emitted++;
      end
      if (a == 0) exp_st = 0;
      else if (flush) exp_st = 3;
      else if (a <= 27) exp_st = 1;
      else exp_st = 2;
      @(negedge clk);
      chk("state", 32'(bus.state), 32'(exp_st));
      chk("col", 32'(bus.col), 32'(a % W));
      chk("raddr", 32'(bus.raddr), 32'(a % W));
      chk("row", 32'(bus.row), 32'(a / W));
      chk("wr_sel", 32'(bus.wr_sel), 32'd1 << ((a / W) % 4));
      chk("edg", 32'(bus.edg),
          32'((a % W == 0) || (a % W == W - 1) || (a / W == 0) || (a / W == H - 1)));
      chk("wen", 32'(bus.ram_wen), 32'd1);
      chk("in_ready", 32'(bus.in_ready), 32'(!flush));
      if (a == 1) chk("err_clear", 32'(bus.err_short), 32'd0);
      a++;
    end
    @(posedge clk); #1;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("frame_done", 32'(bus.frame_done), 32'd1);
    chk_origin("done");
    chk("done_ready", 32'(bus.in_ready), 32'd0);
    chk("err_short", 32'(bus.err_short), 32'(tlast_p < 47));
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.frame_done), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.abort = 1'b0;
    #12;
    chk_origin("reset");
    chk("reset_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_err", 32'(bus.err_short), 32'd0);
    chk("reset_done", 32'(bus.frame_done), 32'd0);
    chk("reset_emit", 32'(bus.out_emit), 32'd0);
    rst_n = 1'b1;
    frame(47, 1'b0, -1, 1'b0);   // continuous frame
    frame(47, 1'b1, -1, 1'b0);   // valid gaps in STREAM
    frame(20, 1'b0, -1, 1'b0);   // early tlast in LOAD
    frame(47, 1'b0, 30, 1'b0);   // abort mid-STREAM
    frame(47, 1'b0, -1, 1'b0);
    frame(47, 1'b0, 35, 1'b1);   // async reset mid-frame
    frame(47, 1'b0, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
